// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 active-low matrix keypad scanner.
package keypad_pkg;

  localparam int NUM_COLS  = 4;
  localparam int NUM_ROWS  = 4;
  localparam int KEY_W     = 4;
  localparam int NUM_KEYS  = NUM_COLS * NUM_ROWS;
  localparam int COL_IDX_W = 2;

  localparam logic [NUM_COLS-1:0] COL0 = 4'b0111;
  localparam logic [NUM_COLS-1:0] COL1 = 4'b1011;
  localparam logic [NUM_COLS-1:0] COL2 = 4'b1101;
  localparam logic [NUM_COLS-1:0] COL3 = 4'b1110;

  typedef logic [NUM_KEYS-1:0] key_map_t;

  function automatic logic [NUM_COLS-1:0] col_strobe(input logic [COL_IDX_W-1:0] idx);
    case (idx)
      2'd0:    return COL0;
      2'd1:    return COL1;
      2'd2:    return COL2;
      default: return COL3;
    endcase
  endfunction

  function automatic logic [4:0] key_count(input key_map_t m);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_KEYS; i++) n = n + 5'(m[i]);
    return n;
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [KEY_W-1:0] key_index(input key_map_t m);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (m[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_ring.sv
// Rotating column strobe: holds each column low for SCAN_DIV cycles and flags the sample cycle.
module scan_ring
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [NUM_COLS-1:0]  col,
  output logic [COL_IDX_W-1:0] col_idx,
  output logic                 sample_en
);

  localparam int DWELL_W = $clog2(SCAN_DIV);

  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [COL_IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    sample_en = (dwell_q == DWELL_W'(SCAN_DIV - 1));
    dwell_d   = dwell_q + 1'b1;
    idx_d     = idx_q;
    if (sample_en) begin
      dwell_d = '0;
      idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dwell_q <= '0;
      idx_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
    end
  end

  assign col_idx = idx_q;
  assign col     = col_strobe(idx_q);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchronizer, per-frame matrix snapshot, frame debounce and press events.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                multi_key
);

  localparam int STABLE_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [COL_IDX_W-1:0] col_idx;
  logic                 sample_en;

  scan_ring #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_ring (
    .clock     (clock),
    .reset     (reset),
    .col       (col),
    .col_idx   (col_idx),
    .sample_en (sample_en)
  );

  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
  logic [NUM_ROWS-1:0] press;
  logic                frame_end;
  logic [4:0]          count;

  key_map_t             snap_q, snap_d;
  key_map_t             prev_q, prev_d;
  key_map_t             deb_q, deb_d;
  logic [STABLE_W-1:0]  stable_q, stable_d;
  logic [KEY_W-1:0]     code_q, code_d;
  logic                 valid_q, valid_d;
  logic                 held_q, held_d;
  logic                 multi_q, multi_d;

  assign press     = ~row_sync_q;
  assign frame_end = sample_en && (col_idx == COL_IDX_W'(NUM_COLS - 1));

  always_comb begin
    snap_d   = snap_q;
    prev_d   = prev_q;
    stable_d = stable_q;
    deb_d    = deb_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    held_d   = held_q;
    multi_d  = multi_q;

    if (sample_en) snap_d[{col_idx, 2'b00} +: NUM_ROWS] = press;
    count = key_count(snap_d);

    // The frame-end decision sees the snapshot including the column just sampled.
    if (frame_end) begin
      if (snap_d == prev_q) begin
        if (stable_q != STABLE_W'(DEBOUNCE_SCANS)) stable_d = stable_q + 1'b1;
      end else begin
        stable_d = STABLE_W'(1);
        prev_d   = snap_d;
      end
      if (stable_d == STABLE_W'(DEBOUNCE_SCANS)) begin
        deb_d   = snap_d;
        held_d  = |snap_d;
        multi_d = (count >= 5'd2);
        if (count == 5'd1 && snap_d != deb_q) begin
          code_d  = key_index(snap_d);
          valid_d = 1'b1;
        end
      end
    end
  end

  // Synchronizer idles at all-ones so reset never looks like a full-row press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      snap_q     <= '0;
      prev_q     <= '0;
      deb_q      <= '0;
      stable_q   <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      snap_q     <= snap_d;
      prev_q     <= prev_d;
      deb_q      <= deb_d;
      stable_q   <= stable_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
      multi_q    <= multi_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign multi_key = multi_q;

endmodule
